// File: rtl/epidemic_link_tx.sv
// Transmit side of one 8-bit epidemic-routing link: drops expired and recently sent packets,
// queues the survivors and serializes each as header, message ID and payload beats.
module epidemic_link_tx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HIST  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_dst,
  input  logic [3:0] in_ttl,
  input  logic [7:0] in_msg_id,
  input  logic [7:0] in_payload,
  output logic       o_valid,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       drop_dup,
  output logic       drop_ttl,
  output logic       busy
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HPtrW = (HIST > 1) ? $clog2(HIST) : 1;

  localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
  localparam logic [HPtrW-1:0] HistLast = HPtrW'(HIST - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StMid, StPay} state_e;

  state_e           state_q, state_d;

  logic [23:0]      fifo_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [23:0]      head;

  logic [7:0]       hist_id_q [HIST];
  logic [HIST-1:0]  hist_vld_q, hist_vld_d;
  logic [HPtrW-1:0] hist_ptr_q, hist_ptr_d;

  logic             drop_ttl_q, drop_ttl_d;
  logic             drop_dup_q, drop_dup_d;

  logic             accept;
  logic             ttl_zero;
  logic             dup_hit;
  logic             push;
  logic             pop;

  assign in_ready = (count_q != DepthCnt);
  assign accept   = in_valid && in_ready;
  assign ttl_zero = (in_ttl == 4'd0);
  assign push     = accept && !ttl_zero && !dup_hit;
  assign pop      = (state_q == StPay) && i_ready;
  assign head     = fifo_q[rd_ptr_q];

  // IDs still waiting in the FIFO already count as sent, so only the history is searched.
  always_comb begin
    dup_hit = 1'b0;
    for (int unsigned i = 0; i < HIST; i++) begin
      if (hist_vld_q[i] && (hist_id_q[i] == in_msg_id)) begin
        dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    hist_vld_d = hist_vld_q;
    hist_ptr_d = hist_ptr_q;
    if (push) begin
      hist_vld_d[hist_ptr_q] = 1'b1;
      hist_ptr_d = (hist_ptr_q == HistLast) ? '0 : hist_ptr_q + HPtrW'(1);
    end
  end

  always_comb begin
    drop_ttl_d = accept && ttl_zero;
    drop_dup_d = accept && !ttl_zero && dup_hit;
  end

  // A packet pushed in the same cycle as the last PAY still counts, so no bubble before it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StHdr;
      StHdr:  if (i_ready) state_d = StMid;
      StMid:  if (i_ready) state_d = StPay;
      StPay:  if (i_ready) state_d = (count_d != '0) ? StHdr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_data = 8'h00;
    unique case (state_q)
      StHdr:   o_data = head[23:16];
      StMid:   o_data = head[15:8];
      StPay:   o_data = head[7:0];
      default: o_data = 8'h00;
    endcase
  end

  assign o_valid  = (state_q != StIdle);
  assign busy     = (count_q != '0) || (state_q != StIdle);
  assign drop_ttl = drop_ttl_q;
  assign drop_dup = drop_dup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hist_vld_q <= '0;
      hist_ptr_q <= '0;
      drop_ttl_q <= 1'b0;
      drop_dup_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hist_vld_q <= hist_vld_d;
      hist_ptr_q <= hist_ptr_d;
      drop_ttl_q <= drop_ttl_d;
      drop_dup_q <= drop_dup_d;
    end
  end

  // Storage needs no reset: valid bits and the FIFO count gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {in_ttl - 4'd1, in_dst, in_msg_id, in_payload};
      hist_id_q[hist_ptr_q] <= in_msg_id;
    end
  end

endmodule

// File: tb/tb_epidemic_link_tx.sv
// Randomized and directed bench for epidemic_link_tx, checked against a packet-level model
// holding the expected beat queue and the list of recently sent message IDs.
module tb_epidemic_link_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HIST  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_dst = '0;
  logic [3:0] in_ttl = '0;
  logic [7:0] in_msg_id = '0;
  logic [7:0] in_payload = '0;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready = 1'b0;
  logic       drop_dup;
  logic       drop_ttl;
  logic       busy;

  epidemic_link_tx #(.DEPTH(DEPTH), .HIST(HIST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dst     (in_dst),
    .in_ttl     (in_ttl),
    .in_msg_id  (in_msg_id),
    .in_payload (in_payload),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .drop_dup   (drop_dup),
    .drop_ttl   (drop_ttl),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Model state: queued packets as {hdr, msg, pay}, beat index into the head, recent IDs.
  logic [23:0] pkts [$];
  logic [7:0]  hist [$];
  int          beat_idx = 0;
  int          low_cnt  = 0;
  logic        exp_dttl = 1'b0;
  logic        exp_ddup = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit seen(input logic [7:0] id);
    foreach (hist[i]) if (hist[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] head_beat();
    logic [23:0] p;
    p = pkts[0];
    case (beat_idx)
      0:       return p[23:16];
      1:       return p[15:8];
      default: return p[7:0];
    endcase
  endfunction

  // Called at a negedge: compare outputs, drive inputs, model the next rising edge.
  task automatic step(input logic v, input logic [3:0] dst, input logic [3:0] ttl,
                      input logic [7:0] msg, input logic [7:0] pay, input logic rdy);
    logic acc, xfer;
    logic [3:0] ttl_m1;
    check_eq("drop_ttl", {31'b0, drop_ttl}, {31'b0, exp_dttl});
    check_eq("drop_dup", {31'b0, drop_dup}, {31'b0, exp_ddup});
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, pkts.size() < DEPTH});
    check_eq("busy", {31'b0, busy}, {31'b0, pkts.size() != 0});
    if (pkts.size() == 0) begin
      low_cnt = 0;
      check_eq("idle_ovalid", {31'b0, o_valid}, 32'd0);
    end else if (o_valid) begin
      low_cnt = 0;
      check_eq("o_data", {24'b0, o_data}, {24'b0, head_beat()});
    end else begin
      low_cnt++;
      if (low_cnt > 1) check_eq("ovalid_late", {31'b0, o_valid}, 32'd1);
    end

    in_valid = v; in_dst = dst; in_ttl = ttl; in_msg_id = msg; in_payload = pay; i_ready = rdy;

    acc  = v && (pkts.size() < DEPTH);
    xfer = o_valid && rdy;
    if (xfer && pkts.size() != 0) begin
      beat_idx++;
      if (beat_idx == 3) begin
        void'(pkts.pop_front());
        beat_idx = 0;
      end
    end
    exp_dttl = acc && (ttl == 0);
    exp_ddup = acc && (ttl != 0) && seen(msg);
    if (acc && ttl != 0 && !seen(msg)) begin
      ttl_m1 = ttl - 4'd1;
      pkts.push_back({ttl_m1, dst, msg, pay});
      hist.push_back(msg);
      if (hist.size() > HIST) void'(hist.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic send(input logic [3:0] dst, input logic [3:0] ttl, input logic [7:0] msg,
                      input logic [7:0] pay);
    step(1'b1, dst, ttl, msg, pay, 1'b1);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the asynchronous response.
  task automatic do_reset();
    in_valid = 1'b0;
    i_ready  = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("rst_ovalid", {31'b0, o_valid}, 32'd0);
    check_eq("rst_odata", {24'b0, o_data}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_drops", {30'b0, drop_dup, drop_ttl}, 32'd0);
    pkts.delete();
    hist.delete();
    beat_idx = 0;
    low_cnt  = 0;
    exp_dttl = 1'b0;
    exp_ddup = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_mid();
    for (int i = 0; i < 10 && !(o_valid && beat_idx == 1); i++) idle(1);
    check_eq("reach_mid", {31'b0, o_valid && beat_idx == 1}, 32'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single packet and first-beat latency.
    send(4'd3, 4'd5, 8'h2A, 8'hC3);
    check_eq("lat_e0_ovalid", {31'b0, o_valid}, 32'd0);
    idle(1);
    check_eq("lat_hdr", {23'b0, o_valid, o_data}, {23'b0, 1'b1, 8'h43});
    idle(4);
    check_eq("busy_after_pay", {31'b0, busy}, 32'd0);

    // Filters: duplicate, expired, then the expired ID sent properly.
    do_reset();
    send(4'd1, 4'd4, 8'h2A, 8'h11);
    send(4'd1, 4'd4, 8'h2A, 8'h22);
    check_eq("dup_pulse", {31'b0, drop_dup}, 32'd1);
    send(4'd2, 4'd0, 8'h55, 8'h33);
    check_eq("ttl_pulse", {31'b0, drop_ttl}, 32'd1);
    send(4'd2, 4'd2, 8'h55, 8'h44);
    idle(8);

    // Backpressure in MID while the FIFO fills.
    do_reset();
    send(4'd6, 4'd7, 8'h60, 8'hA0);
    wait_mid();
    for (int i = 1; i <= 5; i++)
      step(1'b1, 4'(i), 4'd7, 8'(8'h60 + i), 8'(8'hA0 + i), 1'b0);
    check_eq("bp_mid_data", {23'b0, o_valid, o_data}, {23'b0, 1'b1, 8'h60});
    check_eq("bp_full", {31'b0, in_ready}, 32'd0);
    idle(16);

    // Back-to-back: nine valid beats without a bubble.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 4'd9, 8'(8'h70 + i), 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 9; i++) begin
      check_eq("b2b_valid", {31'b0, o_valid}, 32'd1);
      idle(1);
    end
    idle(2);

    // History wrap.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      send(4'd5, 4'd3, 8'(i), 8'(8'hD0 + i));
      check_eq("wrap_accept", {31'b0, drop_dup}, 32'd0);
      idle(3);
    end
    send(4'd5, 4'd3, 8'h00, 8'hE0);
    check_eq("wrap_evicted", {31'b0, drop_dup}, 32'd0);
    idle(3);
    send(4'd5, 4'd3, 8'h08, 8'hE8);
    check_eq("wrap_dup8", {31'b0, drop_dup}, 32'd1);
    idle(4);

    // Reset mid-packet clears queue and history.
    do_reset();
    send(4'd4, 4'd6, 8'h90, 8'h01);
    send(4'd4, 4'd6, 8'h91, 8'h02);
    wait_mid();
    do_reset();
    send(4'd4, 4'd6, 8'h90, 8'h03);
    check_eq("post_rst_accept", {31'b0, drop_dup}, 32'd0);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 9) < 7);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/epidemic_link_tx.md
# epidemic_link_tx

Transmit end of one 8-bit valid/ready node-to-node link in the epidemic-routing grid NoC. It accepts whole packets from the local node logic and applies the epidemic filters: it drops packets whose TTL is expired, and drops packets whose message ID was recently sent. Surviving packets are queued and serialized as three link beats toward the neighbour's receive port. One instance drives each of a node's l/r/t/b output ports.

## Interface
- DEPTH, 4: packet FIFO entries. Power of 2, ≥2.
- HIST, 8: message-ID history entries. ≥1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  local packet offered.
- in_ready  out  1  packet FIFO not full.
- in_dst  in  4  destination node ID.
- in_ttl  in  4  remaining hop count.
- in_msg_id  in  8  epidemic message identifier.
- in_payload  in  8  payload byte.
- o_valid  out  1  link beat valid.
- o_data  out  8  link beat.
- i_ready  in  1  neighbour can accept the beat.
- drop_dup  out  1  one-cycle pulse: duplicate discarded.
- drop_ttl  out  1  one-cycle pulse: expired packet discarded.
- busy  out  1  FIFO non-empty or serializer not IDLE.

## Operation
**Accept**
- A packet is accepted on an edge where in_valid && in_ready.
- in_ready = !full. It does not look ahead at a same-cycle pop.

**Filter, evaluated in the accept cycle**
- Priority 1: in_ttl == 0. The packet is discarded and the history is not touched. drop_ttl pulses.
- Priority 2: in_msg_id matches any valid history entry. The packet is discarded and drop_dup pulses.
- Otherwise:
  - Write {in_ttl-1, in_dst, in_msg_id, in_payload} into the FIFO.
  - Write in_msg_id into the history slot at the round-robin pointer, set its valid bit, and advance the pointer mod HIST. The oldest entry is overwritten.

**History semantics**
- The history is updated at accept time, so IDs still queued in the FIFO already count as sent.

**Link format (3 beats per packet)**
- Beat 0 (HDR): {ttl-1[3:0], dst[3:0]}.
- Beat 1 (MID): msg_id.
- Beat 2 (PAY): payload.

**Serializer FSM**
- States: IDLE, HDR, MID, PAY.
- IDLE → HDR when the FIFO is non-empty.
- HDR → MID, and MID → PAY, on o_valid && i_ready.
- PAY on transfer: pop the FIFO head.
  - If more packets remain after the pop → HDR, with no bubble.
  - Otherwise → IDLE.
- o_valid = (state != IDLE). o_data is muxed from the FIFO head by state.

**Handshake rules**
- Once o_valid is high, it stays high and o_data stays stable until i_ready is sampled high.
- o_valid is never retracted mid-packet.

**Simultaneous events**
- An accept and a PAY pop in the same cycle are both performed; the count is unchanged.

## Timing
**Reset values (rst high)**
- State = IDLE, FIFO empty, all history valid bits cleared, history pointer = 0.
- o_valid = 0, o_data = 0, drop_dup = 0, drop_ttl = 0, busy = 0.
- in_ready = 1.

**Reset mid-packet**
- o_valid falls immediately (asynchronous).
- The partial packet and all queued packets are lost.

**Latency**
- Accept at edge E0 → FIFO count = 1 → state HDR at E1 → o_valid high after E1.
- Minimum: 3 beats per packet, one per cycle while i_ready = 1.

**Drop pulses**
- Registered: high for exactly the cycle after the discarding accept edge.
- Back-to-back discards give consecutive pulses.

**Edge values**
- TTL arithmetic is 4-bit. in_ttl = 1 is sent with TTL 0.
- History hits need an exact 8-bit match on a valid entry.

## Test plan
1. Single packet: dst=3, ttl=5, msg=0x2A, payload=0xC3, i_ready=1 → o_data = 0x43, 0x2A, 0xC3 on consecutive cycles; o_valid first high after the 2nd edge following accept; busy falls after PAY.
2. Filters:
   - msg 0x2A sent twice → second discarded, drop_dup pulses once, only 3 link beats.
   - ttl=0 with msg 0x55 → drop_ttl pulses, no beats.
   - Then msg 0x55 with ttl=2 → sent with header 0x1?.
3. Backpressure: hold i_ready=0 for 5 cycles while in MID → o_valid=1 and o_data=msg held stable; meanwhile queue DEPTH packets → in_ready=0; release → all remaining beats drain in order.
4. Back-to-back: 3 packets queued, i_ready=1 → 9 consecutive valid beats, no bubble between PAY and the next HDR.
5. History wrap, HIST=8:
   - Send IDs 0x00..0x08 → all accepted.
   - Resend 0x00 → accepted (evicted).
   - Resend 0x08 → dropped (drop_dup).
6. Reset: assert rst during MID of the first of 2 queued packets → o_valid=0 immediately, busy=0, in_ready=1; after release, a resent msg ID is accepted (history cleared).
